// File: rtl/dma_stream_scheduler_pkg.sv
// rtl/dma_stream_scheduler_pkg.sv - shared FSM states, descriptor typedef macro and helpers for the DMA stream scheduler
`ifndef DMA_STREAM_SCHEDULER_PKG_SV
`define DMA_STREAM_SCHEDULER_PKG_SV

// Declares a packed descriptor struct from caller-chosen address/length types,
// so each instance can size it from its own parameters.
`define DMA_SCHED_TYPEDEF_DESC(desc_name, addr_type, len_type) \
  typedef struct packed { \
    addr_type src; \
    addr_type dst; \
    len_type  len; \
  } desc_name;

package dma_stream_scheduler_pkg;

  // Raw encodings kept as constants for tools that expect plain vectors.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARB   = ST_ARB,
    ISSUE = ST_ISSUE
  } state_e;

  // Descriptor at the default widths (64-bit addresses, 32-bit length).
  typedef logic [63:0] addr_default_t;
  typedef logic [31:0] len_default_t;
  `DMA_SCHED_TYPEDEF_DESC(desc_default_t, addr_default_t, len_default_t)

  // A credit counter must hold 0..MAX_OUTSTANDING inclusive.
  function automatic int credit_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

`endif

// File: rtl/dma_sched_id_fifo.sv
// rtl/dma_sched_id_fifo.sv - per-stream FIFO of in-flight transfer IDs, in issue order
module dma_sched_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop may happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dma_stream_scheduler.sv
// rtl/dma_stream_scheduler.sv - round-robin DMA descriptor scheduler with in-order retirement; DMA_STREAM_SCHEDULER_STATS_EN adds stat counters
module dma_stream_scheduler
  import dma_stream_scheduler_pkg::*;
#(
  parameter int NUM_STREAMS     = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TF_ID_WIDTH     = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tf_valid_i,
  output logic                   tf_ready_o,
  input  logic [ADDR_WIDTH-1:0]  tf_src_i,
  input  logic [ADDR_WIDTH-1:0]  tf_dst_i,
  input  logic [LEN_WIDTH-1:0]   tf_len_i,
  output logic [TF_ID_WIDTH-1:0] tf_id_o,
  output logic [NUM_STREAMS-1:0] str_valid_o,
  input  logic [NUM_STREAMS-1:0] str_ready_i,
  output logic [ADDR_WIDTH-1:0]  str_src_o,
  output logic [ADDR_WIDTH-1:0]  str_dst_o,
  output logic [LEN_WIDTH-1:0]   str_len_o,
  input  logic [NUM_STREAMS-1:0] str_done_i,
  output logic [TF_ID_WIDTH-1:0] completed_id_o,
  output logic                   busy_o,
  output logic                   done_err_o
`ifdef DMA_STREAM_SCHEDULER_STATS_EN
  ,
  output logic [31:0]            stat_issued_o [NUM_STREAMS],
  output logic [31:0]            stat_stall_o
`endif
);

  localparam int CW  = credit_width(MAX_OUTSTANDING);
  localparam int SW  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int NID = 2 ** TF_ID_WIDTH;
  localparam logic [TF_ID_WIDTH:0]   WINDOW     = (TF_ID_WIDTH+1)'(NUM_STREAMS * MAX_OUTSTANDING);
  localparam logic [CW-1:0]          CREDIT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [TF_ID_WIDTH-1:0] ID_ONE     = TF_ID_WIDTH'(1);

  // The ID space must exceed the in-flight window so inflight never aliases.
  if (NID <= NUM_STREAMS * MAX_OUTSTANDING) begin : g_bad_id_width
    $error("dma_stream_scheduler: 2**TF_ID_WIDTH must exceed NUM_STREAMS*MAX_OUTSTANDING");
  end
  if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_outstanding
    $error("dma_stream_scheduler: MAX_OUTSTANDING must be a power of 2 and at least 2");
  end

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [LEN_WIDTH-1:0]  len_t;
  `DMA_SCHED_TYPEDEF_DESC(desc_t, addr_t, len_t)

  state_e                 state;
  desc_t                  desc;
  logic [TF_ID_WIDTH-1:0] next_id;
  logic [TF_ID_WIDTH-1:0] completed_id;
  logic [TF_ID_WIDTH-1:0] inflight;
  logic [TF_ID_WIDTH-1:0] retire_id;
  logic [SW-1:0]          rr_ptr;
  logic [SW-1:0]          sel;
  logic [SW-1:0]          arb_sel;
  logic                   arb_found;
  logic [CW-1:0]          credit [NUM_STREAMS];
  logic [NID-1:0]         done_bits;
  logic                   done_err;
  logic                   tf_fire;
  logic                   issue_fire;
  logic [NUM_STREAMS-1:0] push;
  logic [NUM_STREAMS-1:0] pop;
  logic [NUM_STREAMS-1:0] credit_zero;
  logic [NUM_STREAMS-1:0] eligible;
  logic [NUM_STREAMS-1:0] fifo_empty;
  logic [NUM_STREAMS-1:0] fifo_full;
  logic [TF_ID_WIDTH-1:0] fifo_head [NUM_STREAMS];

  assign inflight   = next_id - completed_id - ID_ONE;
  assign retire_id  = completed_id + ID_ONE;
  assign tf_ready_o = (state == IDLE) && ({1'b0, inflight} < WINDOW) && !rst_i;
  assign tf_fire    = tf_valid_i && tf_ready_o;
  assign tf_id_o    = next_id;
  assign issue_fire = (state == ISSUE) && str_ready_i[sel];

  assign str_src_o      = desc.src;
  assign str_dst_o      = desc.dst;
  assign str_len_o      = desc.len;
  assign completed_id_o = completed_id;
  assign busy_o         = (state != IDLE) || (inflight != '0);
  assign done_err_o     = done_err;

  // Per-stream issue/retire strobes; a done on an empty stream is dropped.
  always_comb begin
    push        = '0;
    pop         = '0;
    credit_zero = '0;
    eligible    = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      push[k]        = issue_fire && (sel == SW'(k));
      credit_zero[k] = (credit[k] == '0);
      pop[k]         = str_done_i[k] && !credit_zero[k] && !fifo_empty[k];
      eligible[k]    = (credit[k] != CREDIT_MAX) && !fifo_full[k];
    end
  end

  // Round-robin search from rr_ptr; lowest offset wins, so scan offsets downwards.
  always_comb begin
    logic [SW:0] cand;
    arb_found = 1'b0;
    arb_sel   = '0;
    cand      = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (SW+1)'(i);
      if (cand >= (SW+1)'(NUM_STREAMS)) cand = cand - (SW+1)'(NUM_STREAMS);
      if (eligible[cand[SW-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = cand[SW-1:0];
      end
    end
  end

  // One-hot issue valid for the selected stream while in ISSUE.
  always_comb begin
    str_valid_o = '0;
    if (state == ISSUE) str_valid_o[sel] = 1'b1;
  end

  // Control FSM: accept descriptor, pick a stream, hold the issue until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      next_id <= '0;
      rr_ptr  <= '0;
      sel     <= '0;
      desc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tf_fire) begin
            desc    <= '{src: tf_src_i, dst: tf_dst_i, len: tf_len_i};
            next_id <= next_id + ID_ONE;
            state   <= ARB;
          end
        end
        ARB: begin
          if (arb_found) begin
            sel   <= arb_sel;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            rr_ptr <= (sel == SW'(NUM_STREAMS - 1)) ? '0 : sel + SW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit tracks FIFO occupancy; simultaneous push and pop cancel.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_STREAMS; k++) begin
      if (rst_i) begin
        credit[k] <= '0;
      end else if (push[k] && !pop[k]) begin
        credit[k] <= credit[k] + CW'(1);
      end else if (!push[k] && pop[k]) begin
        credit[k] <= credit[k] - CW'(1);
      end
    end
  end

  // Mark completed IDs and retire at most one in order per cycle from registered bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_bits    <= '0;
      completed_id <= '1;
    end else begin
      if (done_bits[retire_id]) begin
        done_bits[retire_id] <= 1'b0;
        completed_id         <= retire_id;
      end
      for (int k = 0; k < NUM_STREAMS; k++) begin
        if (pop[k]) done_bits[fifo_head[k]] <= 1'b1;
      end
    end
  end

  // Sticky flag for a completion arriving on a stream with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_err <= 1'b0;
    end else if (|(str_done_i & credit_zero)) begin
      done_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_fifo
    dma_sched_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (TF_ID_WIDTH)
    ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push[g]),
      .push_data (next_id - ID_ONE),
      .pop       (pop[g]),
      .head      (fifo_head[g]),
      .empty     (fifo_empty[g]),
      .full      (fifo_full[g])
    );
  end

`ifdef DMA_STREAM_SCHEDULER_STATS_EN
  logic stall;
  assign stall = ((state == ARB) && !arb_found) || ((state == ISSUE) && !str_ready_i[sel]);

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_stall_o <= '0;
    end else if (stall && (stat_stall_o != '1)) begin
      stat_stall_o <= stat_stall_o + 32'd1;
    end
  end

  // Saturating per-stream issue counters.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_STREAMS; k++) begin
      if (rst_i) begin
        stat_issued_o[k] <= '0;
      end else if (push[k] && (stat_issued_o[k] != '1)) begin
        stat_issued_o[k] <= stat_issued_o[k] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dma_stream_scheduler.sv
// tb/tb_dma_stream_scheduler.sv - self-checking bench for dma_stream_scheduler
module tb_dma_stream_scheduler;

  localparam int NS = 4;
  localparam int AW = 64;
  localparam int LW = 32;
  localparam int MO = 4;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          tf_valid;
  logic          tf_ready;
  logic [AW-1:0] tf_src;
  logic [AW-1:0] tf_dst;
  logic [LW-1:0] tf_len;
  logic [IW-1:0] tf_id;
  logic [NS-1:0] str_valid;
  logic [NS-1:0] str_ready;
  logic [AW-1:0] str_src;
  logic [AW-1:0] str_dst;
  logic [LW-1:0] str_len;
  logic [NS-1:0] str_done;
  logic [IW-1:0] completed_id;
  logic          busy;
  logic          done_err;
`ifdef DMA_STREAM_SCHEDULER_STATS_EN
  logic [31:0]   stat_issued [NS];
  logic [31:0]   stat_stall;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dma_stream_scheduler #(
    .NUM_STREAMS     (NS),
    .ADDR_WIDTH      (AW),
    .LEN_WIDTH       (LW),
    .MAX_OUTSTANDING (MO),
    .TF_ID_WIDTH     (IW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tf_valid_i     (tf_valid),
    .tf_ready_o     (tf_ready),
    .tf_src_i       (tf_src),
    .tf_dst_i       (tf_dst),
    .tf_len_i       (tf_len),
    .tf_id_o        (tf_id),
    .str_valid_o    (str_valid),
    .str_ready_i    (str_ready),
    .str_src_o      (str_src),
    .str_dst_o      (str_dst),
    .str_len_o      (str_len),
    .str_done_i     (str_done),
    .completed_id_o (completed_id),
    .busy_o         (busy),
    .done_err_o     (done_err)
`ifdef DMA_STREAM_SCHEDULER_STATS_EN
    ,
    .stat_issued_o  (stat_issued),
    .stat_stall_o   (stat_stall)
`endif
  );

  typedef struct {
    logic          rst;
    logic          tf_valid;
    logic [NS-1:0] str_done;
    logic          exp_tf_ready;
    logic [NS-1:0] exp_str_valid;
    logic [IW-1:0] exp_completed;
    logic          exp_busy;
    logic [IW-1:0] exp_tf_id;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int oh_idx(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tf_valid = 1'b0; str_done = '0; str_ready = '1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic pulse_done(input logic [NS-1:0] m);
    @(negedge clk);
    str_done = m;
    @(negedge clk);
    str_done = '0;
    #1;
  endtask

  // Returns in the ISSUE cycle (before its edge) with the assigned ID and stream.
  task automatic send_desc(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [LW-1:0] l, output int id, output int stream);
    int guard;
    @(negedge clk);
    tf_valid = 1'b1; tf_src = s; tf_dst = d; tf_len = l;
    #1;
    guard = 0;
    while (!tf_ready && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    chk("accept_seen", tf_ready, 1);
    id = int'(tf_id);
    @(negedge clk);
    tf_valid = 1'b0;
    #1;
    guard = 0;
    while (str_valid == '0 && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    chk("issue_seen", str_valid != '0, 1);
    stream = oh_idx(str_valid);
    if (stream >= 0) begin
      chk("issue_src", str_src, s);
      chk("issue_dst", str_dst, d);
      chk("issue_len", str_len, l);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int st;
    rst = 1'b1; tf_valid = 1'b0; str_done = '0; str_ready = '1;
    tf_src = '0; tf_dst = '0; tf_len = '0;

    // Single descriptor: reset state, N+2 issue latency, retirement and busy drop.
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h1F, 1'b0, 5'd0};
    vecs[1] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 5'h1F, 1'b0, 5'd0};
    vecs[2] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h1F, 1'b1, 5'd1};
    vecs[3] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 5'h1F, 1'b1, 5'd1};
    vecs[4] = '{1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, 5'h1F, 1'b1, 5'd1};
    vecs[5] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 5'h1F, 1'b1, 5'd1};
    vecs[6] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 5'h00, 1'b0, 5'd1};

    do_reset();
    tf_src = 64'h1000_0000; tf_dst = 64'h8000_0000; tf_len = 32'd64;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; tf_valid = vecs[i].tf_valid; str_done = vecs[i].str_done;
      #1;
      chk($sformatf("t1[%0d] tf_ready", i), tf_ready, vecs[i].exp_tf_ready);
      chk($sformatf("t1[%0d] str_valid", i), str_valid, vecs[i].exp_str_valid);
      chk($sformatf("t1[%0d] completed_id", i), completed_id, vecs[i].exp_completed);
      chk($sformatf("t1[%0d] busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("t1[%0d] tf_id", i), tf_id, vecs[i].exp_tf_id);
      chk($sformatf("t1[%0d] done_err", i), done_err, 1'b0);
      if (vecs[i].exp_str_valid != '0) begin
        chk("t1 str_src", str_src, 64'h1000_0000);
        chk("t1 str_dst", str_dst, 64'h8000_0000);
        chk("t1 str_len", str_len, 64'd64);
      end
    end

    // Back-to-back: round-robin 0,1,2,3,0,1,2,3 with sequential IDs.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_desc(64'h100 * i, 64'h9000 + i, 32'd16 + i, id, st);
      chk($sformatf("t2[%0d] id", i), id, i);
      chk($sformatf("t2[%0d] stream", i), st, i % NS);
    end

    // Out-of-order completion retires only once ID 0 lands, then one per cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_desc(64'hA000 + i, 64'hB000 + i, 32'd8, id, st);
      chk($sformatf("t3[%0d] stream", i), st, i);
    end
    pulse_done(4'b1000);
    pulse_done(4'b0010);
    pulse_done(4'b0100);
    @(negedge clk); #1;
    chk("t3 held completed", completed_id, 5'h1F);
    pulse_done(4'b0001);
    chk("t3 not yet retired", completed_id, 5'h1F);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      chk($sformatf("t3 retire step %0d", j), completed_id, j);
    end
    chk("t3 busy drop", busy, 1'b0);

    // Credit exhaustion: 16 in flight closes the window until ID 0 retires.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_desc(64'hC000 + i, 64'hD000 + i, 32'd4, id, st);
      chk($sformatf("t4[%0d] stream", i), st, i % NS);
    end
    @(negedge clk);
    tf_valid = 1'b1;
    #1;
    chk("t4 17th blocked", tf_ready, 1'b0);
    tf_valid = 1'b0;
    pulse_done(4'b0100);
    chk("t4 done2 no retire", completed_id, 5'h1F);
    chk("t4 done2 window full", tf_ready, 1'b0);
    @(negedge clk); #1;
    chk("t4 still no retire", completed_id, 5'h1F);
    chk("t4 still full", tf_ready, 1'b0);
    pulse_done(4'b0001);
    @(negedge clk); #1;
    chk("t4 retire id0", completed_id, 5'h00);
    chk("t4 window reopens", tf_ready, 1'b1);
    send_desc(64'hE000, 64'hF000, 32'd32, id, st);
    chk("t4 next id", id, 16);
    chk("t4 next stream", st, 0);

    // Backpressure on stream 1 holds valid and payload; spurious done is sticky.
    do_reset();
    send_desc(64'h11, 64'h22, 32'd3, id, st);
    chk("t5 first stream", st, 0);
    str_ready = 4'b1101;
    send_desc(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 32'hCAFE_0001, id, st);
    chk("t5 second stream", st, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t5 hold valid %0d", i), str_valid, 4'b0010);
      chk($sformatf("t5 hold src %0d", i), str_src, 64'h1234_5678_9ABC_DEF0);
      chk($sformatf("t5 hold len %0d", i), str_len, 32'hCAFE_0001);
      chk($sformatf("t5 blocked %0d", i), tf_ready, 1'b0);
    end
    str_ready = '1;
    @(negedge clk); #1;
    chk("t5 released", str_valid, 4'b0000);
    chk("t5 ready after issue", tf_ready, 1'b1);
    chk("t5 no err yet", done_err, 1'b0);
    pulse_done(4'b1000);
    chk("t5 done_err set", done_err, 1'b1);
    chk("t5 spurious no retire", completed_id, 5'h1F);
    pulse_done(4'b0011);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t5 both retired", completed_id, 5'h01);
    chk("t5 idle", busy, 1'b0);
    chk("t5 done_err sticky", done_err, 1'b1);

    // Reset with six in flight drops everything.
    do_reset();
    for (int i = 0; i < 6; i++) send_desc(64'h500 + i, 64'h600 + i, 32'd1, id, st);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6 busy", busy, 1'b0);
    chk("t6 completed", completed_id, 5'h1F);
    chk("t6 str_valid", str_valid, 4'b0000);
    chk("t6 tf_id", tf_id, 5'd0);
    send_desc(64'h700, 64'h800, 32'd2, id, st);
    chk("t6 restart id", id, 0);
    chk("t6 restart stream", st, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dma_stream_scheduler.md
Name: dma_stream_scheduler

Overview:
Distributes 1D DMA transfer descriptors from the cluster DMA frontend onto NUM_STREAMS parallel backend streams. These are the streams that feed the DMA AXI crossbar slave ports. Each accepted descriptor gets a sequential transfer ID, and stream choice is round-robin over streams with free credit. Out-of-order per-stream completions are retired into an in-order completed-ID counter, which the frontend polls for wait/termination events.

Parameters:
NUM_STREAMS, 4, number of backend streams (≥1)
ADDR_WIDTH, 64, src/dst address width
LEN_WIDTH, 32, transfer length width (bytes)
MAX_OUTSTANDING, 4, max in-flight transfers per stream (power of 2, ≥2)
TF_ID_WIDTH, 5, transfer ID width; 2^TF_ID_WIDTH > NUM_STREAMS*MAX_OUTSTANDING (elaboration $error otherwise)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
tf_valid_i  in  1  descriptor valid
tf_ready_o  out  1  descriptor accept
tf_src_i  in  ADDR_WIDTH  source address
tf_dst_i  in  ADDR_WIDTH  destination address
tf_len_i  in  LEN_WIDTH  length
tf_id_o  out  TF_ID_WIDTH  ID given to descriptor; valid in handshake cycle
str_valid_o  out  NUM_STREAMS  one-hot issue valid
str_ready_i  in  NUM_STREAMS  per-stream accept
str_src_o  out  ADDR_WIDTH  shared issue source
str_dst_o  out  ADDR_WIDTH  shared issue destination
str_len_o  out  LEN_WIDTH  shared issue length
str_done_i  in  NUM_STREAMS  one-cycle pulse per completed transfer, in issue order within a stream
completed_id_o  out  TF_ID_WIDTH  highest ID with all IDs ≤ it retired
busy_o  out  1  any descriptor held, in flight or pending retirement
done_err_o  out  1  sticky: str_done_i on a stream with zero outstanding

Behaviour:
- Reset (rst_i sampled high at posedge): FSM→IDLE; next_id=0; completed_id_o='1 (none retired); rr_ptr=0; all credits 0; ID FIFOs and done bitmap cleared; str_valid_o=0; tf_ready_o=0 during reset; busy_o=0; done_err_o=0. Mid-operation reset drops all in-flight state, with no completion reported for it.
- Window: inflight = (next_id − completed_id_o − 1) mod 2^TF_ID_WIDTH. tf_ready_o = (state==IDLE) & (inflight < NUM_STREAMS*MAX_OUTSTANDING).
- FSM IDLE: on tf_valid_i&tf_ready_o, capture descriptor and tf_id_o=next_id; next_id++ (wraps) → ARB.
- FSM ARB: select the first stream k, scanning rr_ptr, rr_ptr+1, … mod NUM_STREAMS, with credit[k] < MAX_OUTSTANDING. Register sel=k → ISSUE. If no stream is eligible, stay in ARB.
- FSM ISSUE: str_valid_o[sel]=1 and str_src/dst/len_o=held descriptor. str_valid_o is held and the payload kept stable until str_ready_i[sel] (no retraction). On the handshake: push ID into FIFO[sel]; credit[sel]++; rr_ptr=sel+1 mod NUM_STREAMS → IDLE.
- Latency: descriptor handshake at cycle N → str_valid_o at N+2 earliest. Peak throughput is one descriptor per 3 cycles.
- Completion: for each k with str_done_i[k], pop FIFO[k] head, set done_bit[id], credit[k]--. All streams can complete in the same cycle. An issue handshake and a done on the same stream in one cycle leave credit unchanged. The FIFO does push and pop together.
- Done with credit[k]==0: ignored, done_err_o set sticky until reset.
- Retire: each cycle, if done_bit[completed_id_o+1] is set, clear it and increment completed_id_o (wraps). At most one retirement per cycle. A done bit set this cycle is retired no earlier than the next cycle.
- busy_o = (state≠IDLE) | (inflight≠0).

Optional Feature:
DMA_STREAM_SCHEDULER_STATS_EN
- Defined: adds outputs stat_issued_o[NUM_STREAMS][31:0] (issue handshakes per stream) and stat_stall_o[31:0] (cycles in ARB with no eligible stream, plus cycles in ISSUE with str_ready_i[sel]=0). Counters saturate at '1 and are cleared by reset.
- Undefined: these ports and counters are absent; no other behaviour changes.

Decomposition:
- Package dma_stream_scheduler_pkg:
  - FSM state enum {IDLE, ARB, ISSUE}.
  - Descriptor struct typedef, parameterised via the module's typedef macro pattern.
  - Localparam helper for the credit width: $clog2(MAX_OUTSTANDING+1).
- Sub-module dma_sched_id_fifo: per-stream FIFO, depth MAX_OUTSTANDING, width TF_ID_WIDTH, push/pop/head/empty/full. Instantiated NUM_STREAMS times.

Test Plan:
- Reset release, one descriptor (src=0x1000_0000, dst=0x8000_0000, len=64): tf_id_o=0; str_valid_o=4'b0001 at N+2; after str_done_i[0] pulse, completed_id_o goes from 0x1F to 0x00 and busy_o drops.
- 8 back-to-back descriptors, all str_ready_i=1: streams issued in order 0,1,2,3,0,1,2,3; IDs 0..7.
- Out-of-order completion: IDs 0..3 on streams 0..3; done stream 3, then 1, then 2 → completed_id_o stays 0x1F; done stream 0 → completed_id_o steps 0,1,2,3 on consecutive cycles.
- Credit exhaustion: no dones, 16 descriptors accepted, tf_ready_o=0 on the 17th. One str_done_i[2] retires nothing (ID 0 pending) and the window stays full. A done on stream 0 retires ID 0 and tf_ready_o rises. The next descriptor is issued on stream 0, the first stream with free credit from rr_ptr=0.
- Backpressure: str_ready_i[1]=0 for 5 cycles during ISSUE → str_valid_o and payload stable, no FIFO push. Spurious str_done_i[3] with zero credit → done_err_o=1 sticky.
- Reset asserted with 6 in flight: next cycle busy_o=0, completed_id_o=0x1F, str_valid_o=0.
